axi_lite_slave_mem: RTL and testbench
=====================================

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, address bits on AR/AW channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data bits on R/W channels; strobe width STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, number of DATA_WIDTH-wide storage locations; MEM_DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports, in order (name direction width meaning):
- aclk  in  1  clock, rising edge
- areset  in  1  asynchronous active-high reset
- araddr  in  ADDR_WIDTH  read address
- arvalid in 1 / arready out 1  read address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid out 1 / rready in 1  read data handshake
- awaddr  in  ADDR_WIDTH  write address
- awvalid in 1 / awready out 1  write address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte strobes
- wvalid in 1 / wready out 1  write data handshake
- bresp  out  2  write response
- bvalid out 1 / bready in 1  write response handshake

Function
REQ-006 SHALL implement FSM with states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP; one transaction in flight at a time.
REQ-007 IDLE: arvalid=1 -> RADDR; else awvalid=1 -> WADDR; else stay. Read wins when both valid in same cycle.
REQ-008 RADDR: arready=1; on arvalid&arready capture araddr -> RDATA.
REQ-009 RDATA: rvalid=1; rdata/rresp registered and stable while rvalid=1; on rvalid&rready -> IDLE.
REQ-010 WADDR: awready=1; on awvalid&awready capture awaddr -> WDATA.
REQ-011 WDATA: wready=1; on wvalid&wready perform write per REQ-013, latch bresp -> WRESP.
REQ-012 WRESP: bvalid=1; bresp stable; on bvalid&bready -> IDLE.
REQ-013 Write: byte lane i of mem[addr] updated from wdata only where wstrb[i]=1 and addr < MEM_DEPTH; wstrb all-zero -> no update, bresp OKAY (2'b00).
REQ-014 Address >= MEM_DEPTH: read returns rdata=0, rresp DECERR (2'b11); write leaves memory unchanged, bresp DECERR.
REQ-015 In-range access responds OKAY (2'b00); EXOKAY and SLVERR never generated.
REQ-016 Each ready/valid output SHALL be high only in its own state (arready only RADDR, rvalid only RDATA, awready only WADDR, wready only WDATA, bvalid only WRESP).
REQ-017 Latency: arvalid sampled high in IDLE at edge N -> arready high after edge N, handshake at edge N+1, rvalid high after edge N+1; write analogous, bvalid high the cycle after the W handshake.
REQ-018 wvalid arriving before the AW handshake SHALL be held off (wready=0) until WDATA.
REQ-019 Read in RDATA SHALL reflect the memory contents at the AR handshake; write completed earlier in the same sequence is visible.

Reset
REQ-020 areset=1 SHALL force state IDLE immediately; arready, rvalid, awready, wready, bvalid = 0; rdata = 0; rresp = bresp = 2'b00.
REQ-021 Reset mid-transaction SHALL drop the pending transaction without response; an uncompleted write (no W handshake) SHALL not modify memory.
REQ-022 Memory contents SHALL NOT be cleared by reset; locations never written read as undefined.

Verification
REQ-023 Write addr 0x004 data 0xA5 wstrb 1 -> bresp 2'b00; read 0x004 -> rdata 0xA5, rresp 2'b00.
REQ-024 Write 0x014 = 0x11 (wstrb 1), then write 0x014 = 0x3C with wstrb 0 -> bresp 2'b00; read 0x014 -> 0x11.
REQ-025 Read 0x004 with rready held low 5 cycles -> rvalid=1 and rdata=0xA5 stable all 5 cycles; one transfer on rready=1, then IDLE.
REQ-026 arvalid (0x004) and awvalid (0x014, data 0x77) asserted same cycle -> read completes first returning prior 0xA5, then write accepted; subsequent read 0x014 -> 0x77.
REQ-027 MEM_DEPTH=16: write 0x014 data 0xFF -> bresp 2'b11; read 0x014 -> rdata 0x00, rresp 2'b11; locations 0x000-0x00F unchanged.
REQ-028 Assert areset while bvalid=1 -> bvalid drops same cycle without clock edge; after release, fresh read of the written address returns the written data.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - AXI-Lite slave backed by a byte-strobed memory array.
// One transaction at a time; reads take priority over writes when both arrive together.
module axi_lite_slave_mem #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 4096,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   wire w_ar_ok = ({1'b0, araddr} < DEPTH_L);
   wire w_aw_ok = ({1'b0, r_waddr} < DEPTH_L);
   wire w_wr_en = (r_state == WDATA) && wvalid && w_aw_ok;

   // Storage has no reset so contents survive areset.
   always_ff @(posedge aclk) begin
      if (w_wr_en) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wstrb[i])
               r_mem[r_waddr[IDX_W-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= IDLE;
         r_waddr <= '0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
         bresp   <= RESP_OKAY;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (arvalid) begin
                  r_state <= RADDR;
                  arready <= 1'b1;
               end else if (awvalid) begin
                  r_state <= WADDR;
                  awready <= 1'b1;
               end
            end
            RADDR: begin
               if (arvalid) begin
                  arready <= 1'b0;
                  rvalid  <= 1'b1;
                  r_state <= RDATA;
                  if (w_ar_ok) begin
                     rdata <= r_mem[araddr[IDX_W-1:0]];
                     rresp <= RESP_OKAY;
                  end else begin
                     rdata <= '0;
                     rresp <= RESP_DECERR;
                  end
               end
            end
            RDATA: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            WADDR: begin
               if (awvalid) begin
                  awready <= 1'b0;
                  wready  <= 1'b1;
                  r_waddr <= awaddr;
                  r_state <= WDATA;
               end
            end
            WDATA: begin
               if (wvalid) begin
                  wready  <= 1'b0;
                  bvalid  <= 1'b1;
                  bresp   <= w_aw_ok ? RESP_OKAY : RESP_DECERR;
                  r_state <= WRESP;
               end
            end
            WRESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb/tb_axi_lite_slave_mem.sv - bench for axi_lite_slave_mem, full-depth and 16-deep instances in lockstep.
module tb_axi_lite_slave_mem;

   logic        aclk, areset;
   logic [11:0] araddr, awaddr;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic [7:0]  wdata;
   logic [0:0]  wstrb;

   logic [1:0]      arready_v, rvalid_v, awready_v, wready_v, bvalid_v;
   logic [1:0][7:0] rdata_v;
   logic [1:0][1:0] rresp_v, bresp_v;

   int total = 0;
   int bad   = 0;
   bit mon_en = 0;

   axi_lite_slave_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(4096)) u_big (
      .aclk(aclk), .areset(areset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready_v[0]),
      .rdata(rdata_v[0]), .rresp(rresp_v[0]), .rvalid(rvalid_v[0]), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready_v[0]),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_v[0]),
      .bresp(bresp_v[0]), .bvalid(bvalid_v[0]), .bready(bready));

   axi_lite_slave_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(16)) u_small (
      .aclk(aclk), .areset(areset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready_v[1]),
      .rdata(rdata_v[1]), .rresp(rresp_v[1]), .rvalid(rvalid_v[1]), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready_v[1]),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_v[1]),
      .bresp(bresp_v[1]), .bvalid(bvalid_v[1]), .bready(bready));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a byte array per instance, updated on observed handshakes.
   logic [7:0] mm [2][4096];
   bit         mk [2][4096];
   logic [7:0] e_rd [2];
   bit         e_rk [2];
   logic [1:0] e_rr [2];
   logic [1:0] e_br [2];
   logic [11:0] wa [2];
   int dep [2] = '{4096, 16};

   always @(posedge aclk) begin
      if (!areset) begin
         for (int k = 0; k < 2; k++) begin
            if (arvalid && arready_v[k]) begin
               if (int'(araddr) < dep[k]) begin
                  e_rd[k] <= mm[k][araddr];
                  e_rk[k] <= mk[k][araddr];
                  e_rr[k] <= 2'b00;
               end else begin
                  e_rd[k] <= 8'h00;
                  e_rk[k] <= 1'b1;
                  e_rr[k] <= 2'b11;
               end
            end
            if (awvalid && awready_v[k]) wa[k] <= awaddr;
            if (wvalid && wready_v[k]) begin
               if (int'(wa[k]) < dep[k]) begin
                  e_br[k] <= 2'b00;
                  if (wstrb[0]) begin
                     mm[k][wa[k]] <= wdata;
                     mk[k][wa[k]] <= 1'b1;
                  end
               end else begin
                  e_br[k] <= 2'b11;
               end
            end
         end
      end
   end

   always @(negedge aclk) begin
      if (mon_en && !areset) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("mon_onehot%0d", k),
                int'($countones({arready_v[k], rvalid_v[k], awready_v[k], wready_v[k], bvalid_v[k]}) <= 1), 1);
            if (rvalid_v[k]) begin
               if (e_rk[k]) chk($sformatf("mon_rdata%0d", k), int'(rdata_v[k]), int'(e_rd[k]));
               chk($sformatf("mon_rresp%0d", k), int'(rresp_v[k]), int'(e_rr[k]));
            end
            if (bvalid_v[k]) chk($sformatf("mon_bresp%0d", k), int'(bresp_v[k]), int'(e_br[k]));
         end
      end
   end

   task automatic rd(input logic [11:0] a, input int hold,
                     output logic [7:0] d0, output logic [1:0] r0,
                     output logic [7:0] d1, output logic [1:0] r1);
      int n = 0;
      araddr = a; arvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!arready_v[0] && n < 20);
      chk("ar_latency", n, 1);
      chk("ar_ready_both", int'(arready_v), 3);
      chk("aw_held_off", int'(awready_v), 0);
      chk("rvalid_early", int'(rvalid_v), 0);
      @(negedge aclk);
      arvalid = 1'b0;
      chk("rvalid_up", int'(rvalid_v), 3);
      chk("arready_down", int'(arready_v), 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         chk("rvalid_hold", int'(rvalid_v), 3);
      end
      d0 = rdata_v[0]; r0 = rresp_v[0]; d1 = rdata_v[1]; r1 = rresp_v[1];
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      chk("rvalid_down", int'(rvalid_v), 0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [7:0] d, input logic s, input bit keep_b,
                     output logic [1:0] b0, output logic [1:0] b1);
      int n = 0;
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!awready_v[0] && n < 20);
      chk("aw_latency", n, 1);
      chk("wready_held_off", int'(wready_v), 0);
      @(negedge aclk);
      awvalid = 1'b0;
      chk("wready_up", int'(wready_v), 3);
      @(negedge aclk);
      wvalid = 1'b0;
      chk("bvalid_up", int'(bvalid_v), 3);
      chk("wready_down", int'(wready_v), 0);
      b0 = bresp_v[0]; b1 = bresp_v[1];
      if (!keep_b) begin
         bready = 1'b1;
         @(negedge aclk);
         bready = 1'b0;
         chk("bvalid_down", int'(bvalid_v), 0);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_hs"}, int'({arready_v, rvalid_v, awready_v, wready_v, bvalid_v}), 0);
      chk({nm, "_rdata"}, int'(rdata_v), 0);
      chk({nm, "_resp"}, int'({rresp_v, bresp_v}), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] d0, d1;
      logic [1:0] r0, r1, b0, b1;
      areset = 1'b1; araddr = '0; awaddr = '0; arvalid = 0; rready = 0;
      awvalid = 0; wvalid = 0; bready = 0; wdata = '0; wstrb = '0;
      repeat (2) @(negedge aclk);
      chk_reset_outputs("reset");
      #1 areset = 1'b0;
      mon_en = 1'b1;
      @(negedge aclk);

      for (int i = 0; i < 16; i++) wr(12'(i), 8'(8'h30 + i), 1'b1, 0, b0, b1);

      wr(12'h004, 8'hA5, 1'b1, 0, b0, b1);
      chk("w004_bresp", int'({b0, b1}), 'h0);
      rd(12'h004, 0, d0, r0, d1, r1);
      chk("r004_data0", int'(d0), 'hA5);
      chk("r004_data1", int'(d1), 'hA5);
      chk("r004_resp", int'({r0, r1}), 'h0);

      wr(12'h014, 8'h11, 1'b1, 0, b0, b1);
      chk("w014_bresp", int'({b0, b1}), 'h3);
      wr(12'h014, 8'h3C, 1'b0, 0, b0, b1);
      chk("w014_nostrb_bresp", int'({b0, b1}), 'h3);
      rd(12'h014, 0, d0, r0, d1, r1);
      chk("r014_data0", int'(d0), 'h11);
      chk("r014_data1", int'(d1), 'h00);
      chk("r014_resp", int'({r0, r1}), 'h3);

      rd(12'h004, 5, d0, r0, d1, r1);
      chk("r004_hold_data", int'(d0), 'hA5);

      awaddr = 12'h014; awvalid = 1'b1;
      rd(12'h004, 0, d0, r0, d1, r1);
      chk("race_rd_data", int'(d0), 'hA5);
      wr(12'h014, 8'h77, 1'b1, 0, b0, b1);
      chk("race_wr_bresp0", int'(b0), 0);
      rd(12'h014, 0, d0, r0, d1, r1);
      chk("race_rd_after", int'(d0), 'h77);

      wr(12'h014, 8'hFF, 1'b1, 0, b0, b1);
      chk("oor_bresp1", int'(b1), 3);
      chk("oor_bresp0", int'(b0), 0);
      rd(12'h014, 0, d0, r0, d1, r1);
      chk("oor_rd1", int'({d1, r1}), 'h003);
      rd(12'h010, 0, d0, r0, d1, r1);
      chk("edge_010_rresp1", int'(r1), 3);
      for (int i = 0; i < 16; i++) begin
         rd(12'(i), 0, d0, r0, d1, r1);
         chk($sformatf("keep1_%0d", i), int'(d1), (i == 4) ? 'hA5 : 'h30 + i);
      end
      wr(12'hFFF, 8'h42, 1'b1, 0, b0, b1);
      rd(12'hFFF, 0, d0, r0, d1, r1);
      chk("top_addr0", int'({d0, r0}), 'h108);
      chk("top_addr1", int'(r1), 3);

      wr(12'h030, 8'h12, 1'b1, 0, b0, b1);
      awaddr = 12'h030; awvalid = 1'b1; wdata = 8'hEE; wstrb = 1'b1; wvalid = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      awvalid = 1'b0;
      chk("partial_wready", int'(wready_v), 3);
      #1 areset = 1'b1;
      #1 chk_reset_outputs("midwrite");
      @(negedge aclk);
      #1 areset = 1'b0;
      rd(12'h030, 0, d0, r0, d1, r1);
      chk("partial_kept", int'(d0), 'h12);

      wr(12'h020, 8'h5A, 1'b1, 1, b0, b1);
      chk("keep_bvalid", int'(bvalid_v), 3);
      #1 areset = 1'b1;
      #1 chk("bvalid_async_drop", int'(bvalid_v), 0);
      chk_reset_outputs("resp_reset");
      @(negedge aclk);
      #1 areset = 1'b0;
      rd(12'h020, 0, d0, r0, d1, r1);
      chk("after_reset_rd", int'({d0, r0}), 'h168);

      repeat (2) @(negedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
